// File: rtl/mnist_nn_irq_ctrl.sv
// mnist_nn_irq_ctrl
//
// Interrupt controller for the mnist_nn system. Latches up to NUM_IRQ
// interrupt inputs as edge- or level-sensitive pending bits, masks them with
// a software enable register and drives one prioritised request (lowest
// index wins) with its channel ID. Registers sit on a 16-bit Avalon-MM slave.
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   chipselect slave select
//   address    register word address (0..7)
//   write_n    active-low write strobe
//   writedata  write data
//   readdata   registered read data, valid one cycle after address
//   irq_in     interrupt sources (bit 0 = interval timer)
//   irq        registered CPU interrupt request
//   irq_id     registered ID of highest-priority active channel
//
// Register map: 0 PENDING (W1C), 1 ENABLE, 2 EDGE_SEL, 3 ACTIVE (RO),
//               4 FORCE (WO), 5 RAW (RO), 6-7 reserved.
//
// Build option: define MNIST_NN_IRQ_CTRL_SYNC_EN to pass every irq_in bit
// through a 2-flop synchronizer (needed for sources not clocked by clk).

module mnist_nn_irq_ctrl #(
    parameter int unsigned NUM_IRQ = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               chipselect,
    input  logic [2:0]         address,
    input  logic               write_n,
    input  logic [15:0]        writedata,
    output logic [15:0]        readdata,
    input  logic [NUM_IRQ-1:0] irq_in,
    output logic               irq,
    output logic [3:0]         irq_id
);

    localparam logic [2:0] AddrPending = 3'd0;
    localparam logic [2:0] AddrEnable  = 3'd1;
    localparam logic [2:0] AddrEdgeSel = 3'd2;
    localparam logic [2:0] AddrActive  = 3'd3;
    localparam logic [2:0] AddrForce   = 3'd4;
    localparam logic [2:0] AddrRaw     = 3'd5;

    logic               wr_en;
    logic [NUM_IRQ-1:0] wdata_n;
    logic [NUM_IRQ-1:0] in_s;
    logic [NUM_IRQ-1:0] in_prev_q;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] enable_q;
    logic [NUM_IRQ-1:0] edge_sel_q;
    logic [NUM_IRQ-1:0] set_v, clr_v, act;
    logic               irq_q, irq_d;
    logic [3:0]         irq_id_q, irq_id_d;
    logic [15:0]        readdata_q, readdata_d;

    assign wr_en   = chipselect & ~write_n;
    assign wdata_n = writedata[NUM_IRQ-1:0];

`ifdef MNIST_NN_IRQ_CTRL_SYNC_EN
    logic [NUM_IRQ-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq_in;
            sync2_q <= sync1_q;
        end
    end

    assign in_s = sync2_q;
`else
    assign in_s = irq_in;
`endif

    // Edge channels: set (rise or FORCE) beats a simultaneous W1C.
    // Level channels simply mirror the sampled input.
    always_comb begin
        set_v = in_s & ~in_prev_q;
        clr_v = '0;
        if (wr_en && address == AddrForce) begin
            set_v = set_v | wdata_n;
        end
        if (wr_en && address == AddrPending) begin
            clr_v = wdata_n;
        end
        pending_d = (edge_sel_q & (set_v | (pending_q & ~clr_v))) | (~edge_sel_q & in_s);
    end

    // Lowest index wins: scan downwards so the last hit is the lowest.
    always_comb begin
        act      = pending_q & enable_q;
        irq_d    = |act;
        irq_id_d = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (act[i]) begin
                irq_id_d = 4'(i);
            end
        end
    end

    always_comb begin
        readdata_d = '0;
        case (address)
            AddrPending: readdata_d = 16'(pending_q);
            AddrEnable:  readdata_d = 16'(enable_q);
            AddrEdgeSel: readdata_d = 16'(edge_sel_q);
            AddrActive:  readdata_d = {irq_q, 11'b0, irq_id_q};
            AddrRaw:     readdata_d = 16'(in_s);
            default:     readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_prev_q  <= '0;
            pending_q  <= '0;
            enable_q   <= '0;
            edge_sel_q <= '1;
            irq_q      <= 1'b0;
            irq_id_q   <= '0;
            readdata_q <= '0;
        end else begin
            in_prev_q  <= in_s;
            pending_q  <= pending_d;
            irq_q      <= irq_d;
            irq_id_q   <= irq_id_d;
            readdata_q <= readdata_d;
            if (wr_en && address == AddrEnable) begin
                enable_q <= wdata_n;
            end
            if (wr_en && address == AddrEdgeSel) begin
                edge_sel_q <= wdata_n;
            end
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;
    assign irq_id   = irq_id_q;

endmodule

// File: tb/tb_mnist_nn_irq_ctrl.sv
// Self-checking bench for mnist_nn_irq_ctrl (NUM_IRQ = 8).
// Register traffic comes from a vector table; multi-cycle corner cases are
// hand-written sequences. Read expectations go through a scoreboard queue.

module tb_mnist_nn_irq_ctrl;

`ifdef MNIST_NN_IRQ_CTRL_SYNC_EN
    localparam int SyncLat = 2;
`else
    localparam int SyncLat = 0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        chipselect;
    logic [2:0]  address;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic [7:0]  irq_in;
    logic        irq;
    logic [3:0]  irq_id;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       name;
        logic [15:0] exp;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        bit          wr;
        logic [2:0]  addr;
        logic [15:0] data;
        logic [15:0] exp_rd;
        logic        exp_irq;
        logic [3:0]  exp_id;
    } vec_t;
    vec_t vecs [0:24];

    mnist_nn_irq_ctrl #(.NUM_IRQ(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .chipselect (chipselect),
        .address    (address),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq_in     (irq_in),
        .irq        (irq),
        .irq_id     (irq_id)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h required 0x%04h", nm, act, exp);
        end
    endtask

    task automatic chk_irq(input string nm, input logic ei, input logic [3:0] eid);
        chk({nm, " irq"}, {15'b0, irq}, {15'b0, ei});
        chk({nm, " irq_id"}, {12'b0, irq_id}, {12'b0, eid});
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input string nm, input logic [2:0] a, input logic [15:0] e);
        exp_t x;
        address = a;
        x.name  = nm;
        x.exp   = e;
        sbq.push_back(x);
        tick();
        x = sbq.pop_front();
        chk(x.name, readdata, x.exp);
    endtask

    initial begin
        // {wr, addr, data, exp_rd, exp_irq, exp_id}
        vecs[0]  = '{0, 3'd1, 16'h0000, 16'h0000, 0, 4'd0};
        vecs[1]  = '{0, 3'd2, 16'h0000, 16'h00FF, 0, 4'd0};
        vecs[2]  = '{0, 3'd0, 16'h0000, 16'h0000, 0, 4'd0};
        vecs[3]  = '{1, 3'd1, 16'hFFFF, 16'h0000, 0, 4'd0};
        vecs[4]  = '{0, 3'd1, 16'h0000, 16'h00FF, 0, 4'd0};
        vecs[5]  = '{1, 3'd4, 16'h0024, 16'h0000, 1, 4'd2};
        vecs[6]  = '{0, 3'd0, 16'h0000, 16'h0024, 1, 4'd2};
        vecs[7]  = '{0, 3'd3, 16'h0000, 16'h8002, 1, 4'd2};
        vecs[8]  = '{1, 3'd0, 16'h0004, 16'h0000, 1, 4'd5};
        vecs[9]  = '{0, 3'd3, 16'h0000, 16'h8005, 1, 4'd5};
        vecs[10] = '{1, 3'd0, 16'h0020, 16'h0000, 0, 4'd0};
        vecs[11] = '{0, 3'd3, 16'h0000, 16'h0000, 0, 4'd0};
        vecs[12] = '{0, 3'd4, 16'h0000, 16'h0000, 0, 4'd0};
        vecs[13] = '{1, 3'd3, 16'hFFFF, 16'h0000, 0, 4'd0};
        vecs[14] = '{0, 3'd6, 16'h0000, 16'h0000, 0, 4'd0};
        vecs[15] = '{0, 3'd7, 16'h0000, 16'h0000, 0, 4'd0};
        vecs[16] = '{1, 3'd4, 16'hFF00, 16'h0000, 0, 4'd0};
        vecs[17] = '{0, 3'd0, 16'h0000, 16'h0000, 0, 4'd0};
        vecs[18] = '{1, 3'd2, 16'hFF0F, 16'h0000, 0, 4'd0};
        vecs[19] = '{0, 3'd2, 16'h0000, 16'h000F, 0, 4'd0};
        vecs[20] = '{1, 3'd4, 16'h00F0, 16'h0000, 0, 4'd0};
        vecs[21] = '{0, 3'd0, 16'h0000, 16'h0000, 0, 4'd0};
        vecs[22] = '{1, 3'd2, 16'h00FF, 16'h0000, 0, 4'd0};
        vecs[23] = '{1, 3'd1, 16'h0000, 16'h0000, 0, 4'd0};
        vecs[24] = '{0, 3'd5, 16'h0000, 16'h0000, 0, 4'd0};

        reset_n    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 3'd0;
        writedata  = 16'h0000;
        irq_in     = 8'h00;
        repeat (3) tick();
        chk("reset readdata", readdata, 16'h0000);
        chk_irq("reset", 1'b0, 4'd0);
        reset_n = 1'b1;
        tick();

        // Register map and priority vectors
        for (int i = 0; i < 25; i++) begin
            if (vecs[i].wr) begin
                wr(vecs[i].addr, vecs[i].data);
                tick();
            end else begin
                rd($sformatf("vec%0d readdata", i), vecs[i].addr, vecs[i].exp_rd);
            end
            chk_irq($sformatf("vec%0d", i), vecs[i].exp_irq, vecs[i].exp_id);
        end

        // Timer edge path: one-cycle pulse, irq exactly two cycles after rise
        wr(3'd1, 16'h0001);
        irq_in = 8'h01;
        tick();
        irq_in = 8'h00;
        repeat (SyncLat) tick();
        chk_irq("timer early", 1'b0, 4'd0);
        tick();
        chk_irq("timer irq", 1'b1, 4'd0);
        rd("timer pending", 3'd0, 16'h0001);
        rd("timer active", 3'd3, 16'h8000);
        wr(3'd0, 16'h0001);
        chk_irq("timer w1c edge", 1'b1, 4'd0);
        tick();
        chk_irq("timer w1c drop", 1'b0, 4'd0);

        // Set/clear collision: rise on ch3 in the same cycle as W1C of bit 3
        wr(3'd1, 16'h0008);
        irq_in = 8'h08;
        repeat (SyncLat) tick();
        wr(3'd0, 16'h0008);
        rd("collision pending", 3'd0, 16'h0008);
        chk_irq("collision", 1'b1, 4'd3);
        irq_in = 8'h00;
        repeat (SyncLat + 1) tick();
        wr(3'd0, 16'h0008);
        rd("collision cleared", 3'd0, 16'h0000);

        // Level mode on ch0
        wr(3'd2, 16'h00FE);
        wr(3'd1, 16'h0001);
        irq_in = 8'h01;
        repeat (SyncLat + 2) tick();
        rd("level pending", 3'd0, 16'h0001);
        rd("level raw", 3'd5, 16'h0001);
        chk_irq("level irq", 1'b1, 4'd0);
        wr(3'd0, 16'h0001);
        rd("level w1c ignored", 3'd0, 16'h0001);
        irq_in = 8'h00;
        repeat (SyncLat) tick();
        tick();
        chk_irq("level drop edge", 1'b1, 4'd0);
        tick();
        chk_irq("level drop irq", 1'b0, 4'd0);
        rd("level pending clr", 3'd0, 16'h0000);

        // Level -> edge keeps pending even after the input falls
        irq_in = 8'h01;
        repeat (SyncLat + 2) tick();
        wr(3'd2, 16'h00FF);
        irq_in = 8'h00;
        repeat (SyncLat + 2) tick();
        rd("lvl2edge keep", 3'd0, 16'h0001);
        wr(3'd0, 16'h0001);
        rd("lvl2edge clr", 3'd0, 16'h0000);

        // Mask: pending while disabled, then enable / disable / re-enable
        wr(3'd1, 16'h0000);
        wr(3'd4, 16'h0002);
        tick();
        chk_irq("mask off", 1'b0, 4'd0);
        rd("mask pending", 3'd0, 16'h0002);
        wr(3'd1, 16'h0002);
        tick();
        chk_irq("mask on", 1'b1, 4'd1);
        wr(3'd1, 16'h0000);
        tick();
        chk_irq("mask disable", 1'b0, 4'd0);
        rd("mask pending kept", 3'd0, 16'h0002);
        wr(3'd1, 16'h0002);
        tick();
        chk_irq("mask reenable", 1'b1, 4'd1);
        wr(3'd0, 16'h0002);

        // Reset mid-traffic, with ch1 already high at release
        wr(3'd1, 16'h00FF);
        wr(3'd4, 16'h0010);
        address = 3'd0;
        tick();
        chk_irq("pre-reset", 1'b1, 4'd4);
        irq_in  = 8'h02;
        reset_n = 1'b0;
        #1;
        chk("async reset readdata", readdata, 16'h0000);
        chk_irq("async reset", 1'b0, 4'd0);
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (SyncLat) tick();
        rd("post-reset enable", 3'd1, 16'h0000);
        rd("post-reset edge_sel", 3'd2, 16'h00FF);
        rd("high at release", 3'd0, 16'h0002);
        chk_irq("post-reset", 1'b0, 4'd0);
        irq_in = 8'h00;
        wr(3'd0, 16'h0002);
        rd("post-reset clr", 3'd0, 16'h0000);

        if (sbq.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard drain: got %0d entries required 0", sbq.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
